// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the dual-port data-memory access controller.
package dmem_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/dmem_port_fsm.sv
// One RAM port sequencer: IDLE -> SETUP -> ACCESS -> RESP, with request latching
// and range check. Every output is a flop.
module dmem_port_fsm
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = dmem_pkg::DATA_W,
  parameter int unsigned ADDR_W    = dmem_pkg::ADDR_W,
  parameter int unsigned MEM_DEPTH = dmem_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] ram_dout_i,
  output state_e            state_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_wr_o,
  output logic              ram_rd_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_wr_q, ram_wr_d;
  logic              ram_rd_q, ram_rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              in_range;

  assign in_range = 32'(addr_i) < MEM_DEPTH;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;
    ram_rd_d   = 1'b0;
    rdata_d    = '0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          we_d   = we_i;
          addr_d = addr_i;
          if (in_range) begin
            state_d    = StSetup;
            ram_addr_d = addr_i;
            ram_din_d  = wdata_i;
          end else begin
            // Out-of-range: answer immediately, RAM bus left untouched.
            state_d = StResp;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d  = StAccess;
        ram_wr_d = we_q;
        ram_rd_d = ~we_q;
      end
      StAccess: begin
        state_d = StResp;
        ack_d   = 1'b1;
        rdata_d = we_q ? '0 : ram_dout_i;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_wr_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wr_q   <= ram_wr_d;
      ram_rd_q   <= ram_rd_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign state_o    = state_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign ram_wr_o   = ram_wr_q;
  assign ram_rd_o   = ram_rd_q;
  assign rdata_o    = rdata_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Dual-port data RAM access controller: two port sequencers plus same-address conflict arbiter.
// Define DMEM_RR_ARB_EN for round-robin on simultaneous conflicts (default: core 1 wins).
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = dmem_pkg::DATA_W,
  parameter int unsigned ADDR_W    = dmem_pkg::ADDR_W,
  parameter int unsigned MEM_DEPTH = dmem_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core1_req,
  input  logic              core1_we,
  input  logic [ADDR_W-1:0] core1_addr,
  input  logic [DATA_W-1:0] core1_wdata,
  output logic [DATA_W-1:0] core1_rdata,
  output logic              core1_ack,
  output logic              core1_err,
  input  logic              core2_req,
  input  logic              core2_we,
  input  logic [ADDR_W-1:0] core2_addr,
  input  logic [DATA_W-1:0] core2_wdata,
  output logic [DATA_W-1:0] core2_rdata,
  output logic              core2_ack,
  output logic              core2_err,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [DATA_W-1:0] ram_din_1,
  output logic              ram_wr_1,
  output logic              ram_rd_1,
  input  logic [DATA_W-1:0] ram_dout_1,
  output logic [ADDR_W-1:0] ram_addr_2,
  output logic [DATA_W-1:0] ram_din_2,
  output logic              ram_wr_2,
  output logic              ram_rd_2,
  input  logic [DATA_W-1:0] ram_dout_2
);

  state_e            st1, st2;
  logic              we1_l, we2_l;
  logic [ADDR_W-1:0] addr1_l, addr2_l;
  logic              busy2_blocks1, busy1_blocks2, sim_conf, prio2;
  logic              grant1, grant2;

  // A port holding an address blocks a new request to it unless both are loads.
  assign busy2_blocks1 = (st2 != StIdle) && (addr2_l == core1_addr) && (core1_we || we2_l);
  assign busy1_blocks2 = (st1 != StIdle) && (addr1_l == core2_addr) && (core2_we || we1_l);
  assign sim_conf = core1_req && core2_req && (st1 == StIdle) && (st2 == StIdle) &&
                    (core1_addr == core2_addr) && (core1_we || core2_we);

  assign grant1 = core1_req && (st1 == StIdle) && !busy2_blocks1 && !(sim_conf && prio2);
  assign grant2 = core2_req && (st2 == StIdle) && !busy1_blocks2 && !(sim_conf && !prio2);

`ifdef DMEM_RR_ARB_EN
  logic rr_q, rr_d;

  // Every simultaneous conflict grants the pointed-to core, then hands priority over.
  always_comb begin
    rr_d = rr_q;
    if (sim_conf) rr_d = ~rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  assign prio2 = rr_q;
`else
  assign prio2 = 1'b0;
`endif

  dmem_port_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_port1 (
    .clk       (clk),
    .rst       (rst),
    .grant_i   (grant1),
    .we_i      (core1_we),
    .addr_i    (core1_addr),
    .wdata_i   (core1_wdata),
    .ram_dout_i(ram_dout_1),
    .state_o   (st1),
    .we_o      (we1_l),
    .addr_o    (addr1_l),
    .ram_addr_o(ram_addr_1),
    .ram_din_o (ram_din_1),
    .ram_wr_o  (ram_wr_1),
    .ram_rd_o  (ram_rd_1),
    .rdata_o   (core1_rdata),
    .ack_o     (core1_ack),
    .err_o     (core1_err)
  );

  dmem_port_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_port2 (
    .clk       (clk),
    .rst       (rst),
    .grant_i   (grant2),
    .we_i      (core2_we),
    .addr_i    (core2_addr),
    .wdata_i   (core2_wdata),
    .ram_dout_i(ram_dout_2),
    .state_o   (st2),
    .we_o      (we2_l),
    .addr_o    (addr2_l),
    .ram_addr_o(ram_addr_2),
    .ram_din_o (ram_din_2),
    .ram_wr_o  (ram_wr_2),
    .ram_rd_o  (ram_rd_2),
    .rdata_o   (core2_rdata),
    .ack_o     (core2_ack),
    .err_o     (core2_err)
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural dual-port RAM attached.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core1_req, core1_we, core2_req, core2_we;
  logic [15:0] core1_addr, core1_wdata, core2_addr, core2_wdata;
  logic [15:0] core1_rdata, core2_rdata;
  logic        core1_ack, core1_err, core2_ack, core2_err;
  logic [15:0] ram_addr_1, ram_din_1, ram_dout_1, ram_addr_2, ram_din_2, ram_dout_2;
  logic        ram_wr_1, ram_rd_1, ram_wr_2, ram_rd_2;

  logic [15:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Per-port observations from run(): cycle numbers are 1-based after the accepting edge.
  int          ack_c [2];
  int          ack_n [2];
  int          rd_c [2];
  int          wr_c [2];
  logic [15:0] rdat [2];
  logic        errv [2];
  logic        rd_at_ack [2];
  logic [15:0] addr_at1 [2];
  logic        strobe_at1 [2];

  always #5 clk = ~clk;

  assign ram_dout_1 = ram_rd_1 ? mem[ram_addr_1[9:0]] : 16'h0000;
  assign ram_dout_2 = ram_rd_2 ? mem[ram_addr_2[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pl_en)    mem[pl_addr] <= pl_data;
    if (ram_wr_1) mem[ram_addr_1[9:0]] <= ram_din_1;
    if (ram_wr_2) mem[ram_addr_2[9:0]] <= ram_din_2;
  end

  dmem_access_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .core1_req  (core1_req),
    .core1_we   (core1_we),
    .core1_addr (core1_addr),
    .core1_wdata(core1_wdata),
    .core1_rdata(core1_rdata),
    .core1_ack  (core1_ack),
    .core1_err  (core1_err),
    .core2_req  (core2_req),
    .core2_we   (core2_we),
    .core2_addr (core2_addr),
    .core2_wdata(core2_wdata),
    .core2_rdata(core2_rdata),
    .core2_ack  (core2_ack),
    .core2_err  (core2_err),
    .ram_addr_1 (ram_addr_1),
    .ram_din_1  (ram_din_1),
    .ram_wr_1   (ram_wr_1),
    .ram_rd_1   (ram_rd_1),
    .ram_dout_1 (ram_dout_1),
    .ram_addr_2 (ram_addr_2),
    .ram_din_2  (ram_din_2),
    .ram_wr_2   (ram_wr_2),
    .ram_rd_2   (ram_rd_2),
    .ram_dout_2 (ram_dout_2)
  );

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Observe both ports for maxc cycles; each core drops req once its ack is seen.
  task automatic run(input int maxc);
    for (int p = 0; p < 2; p++) begin
      ack_c[p] = -1; ack_n[p] = 0; rd_c[p] = -1; wr_c[p] = -1;
      rdat[p] = 16'hxxxx; errv[p] = 1'bx; rd_at_ack[p] = 1'bx;
    end
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        addr_at1[0] = ram_addr_1; strobe_at1[0] = ram_rd_1 | ram_wr_1;
        addr_at1[1] = ram_addr_2; strobe_at1[1] = ram_rd_2 | ram_wr_2;
      end
      if (ram_rd_1 && rd_c[0] < 0) rd_c[0] = c;
      if (ram_wr_1 && wr_c[0] < 0) wr_c[0] = c;
      if (ram_rd_2 && rd_c[1] < 0) rd_c[1] = c;
      if (ram_wr_2 && wr_c[1] < 0) wr_c[1] = c;
      if (core1_ack) ack_n[0]++;
      if (core2_ack) ack_n[1]++;
      if (core1_ack && ack_c[0] < 0) begin
        ack_c[0] = c; rdat[0] = core1_rdata; errv[0] = core1_err; rd_at_ack[0] = ram_rd_1;
        core1_req = 1'b0;
      end
      if (core2_ack && ack_c[1] < 0) begin
        ack_c[1] = c; rdat[1] = core2_rdata; errv[1] = core2_err; rd_at_ack[1] = ram_rd_2;
        core2_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ram_wr_1, ram_rd_1, ram_wr_2, ram_rd_2} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b want 0000", {ram_wr_1, ram_rd_1, ram_wr_2, ram_rd_2});
    end
    n_checks++;
    if ({ram_addr_1, ram_din_1, ram_addr_2, ram_din_2} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_ram_bus: got %h want 0", {ram_addr_1, ram_din_1, ram_addr_2, ram_din_2});
    end
    n_checks++;
    if ({core1_rdata, core1_ack, core1_err, core2_rdata, core2_ack, core2_err} !== 36'h0) begin
      n_errors++;
      $display("FAIL reset_core_outs: got %h want 0",
               {core1_rdata, core1_ack, core1_err, core2_rdata, core2_ack, core2_err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load;
    core1_we = 1'b1; core1_addr = 16'd5; core1_wdata = 16'h00AB; core1_req = 1'b1;
    run(6);
    n_checks++;
    if (ack_c[0] !== 3) begin n_errors++; $display("FAIL store_ack_cycle: got %0d want 3", ack_c[0]); end
    n_checks++;
    if (ack_n[0] !== 1) begin n_errors++; $display("FAIL store_ack_width: got %0d want 1", ack_n[0]); end
    n_checks++;
    if (wr_c[0] !== 2) begin n_errors++; $display("FAIL store_wr_cycle: got %0d want 2", wr_c[0]); end
    n_checks++;
    if (rdat[0] !== 16'h0000) begin n_errors++; $display("FAIL store_rdata: got %h want 0000", rdat[0]); end
    n_checks++;
    if (mem[5] !== 16'h00AB) begin n_errors++; $display("FAIL store_mem5: got %h want 00ab", mem[5]); end

    core1_we = 1'b0; core1_req = 1'b1;
    run(6);
    n_checks++;
    if (addr_at1[0] !== 16'd5 || strobe_at1[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL load_setup: got addr %0d strobe %b want addr 5 strobe 0", addr_at1[0], strobe_at1[0]);
    end
    n_checks++;
    if (rd_c[0] !== 2) begin n_errors++; $display("FAIL load_rd_cycle: got %0d want 2", rd_c[0]); end
    n_checks++;
    if (ack_c[0] !== 3 || rdat[0] !== 16'h00AB || errv[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL load_resp: got ack@%0d rdata %h err %b want ack@3 rdata 00ab err 0",
               ack_c[0], rdat[0], errv[0]);
    end
    n_checks++;
    if (rd_at_ack[0] !== 1'b0) begin n_errors++; $display("FAIL load_rd_low_in_resp: got %b want 0", rd_at_ack[0]); end
  endtask

  task automatic test_parallel_loads;
    preload(10'd3, 16'h1234);
    preload(10'd7, 16'hBEEF);
    core1_we = 1'b0; core1_addr = 16'd3; core1_req = 1'b1;
    core2_we = 1'b0; core2_addr = 16'd7; core2_req = 1'b1;
    run(6);
    n_checks++;
    if (ack_c[0] !== 3 || ack_c[1] !== 3) begin
      n_errors++;
      $display("FAIL parallel_ack: got %0d/%0d want 3/3", ack_c[0], ack_c[1]);
    end
    n_checks++;
    if (rdat[0] !== 16'h1234 || rdat[1] !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL parallel_rdata: got %h/%h want 1234/beef", rdat[0], rdat[1]);
    end
  endtask

  task automatic test_out_of_range;
    core2_we = 1'b0; core2_addr = 16'd1024; core2_req = 1'b1;
    run(5);
    n_checks++;
    if (ack_c[1] !== 1 || errv[1] !== 1'b1 || rdat[1] !== 16'h0000) begin
      n_errors++;
      $display("FAIL oor_resp: got ack@%0d err %b rdata %h want ack@1 err 1 rdata 0000",
               ack_c[1], errv[1], rdat[1]);
    end
    n_checks++;
    if (rd_c[1] !== -1) begin n_errors++; $display("FAIL oor_no_rd: got rd@%0d want none", rd_c[1]); end
  endtask

  task automatic test_same_addr_loads;
    preload(10'd9, 16'h0F0F);
    core1_we = 1'b0; core1_addr = 16'd9; core1_req = 1'b1;
    core2_we = 1'b0; core2_addr = 16'd9; core2_req = 1'b1;
    run(6);
    n_checks++;
    if (ack_c[0] !== 3 || ack_c[1] !== 3 || rdat[0] !== 16'h0F0F || rdat[1] !== 16'h0F0F) begin
      n_errors++;
      $display("FAIL shared_loads: got ack %0d/%0d rdata %h/%h want 3/3 0f0f/0f0f",
               ack_c[0], ack_c[1], rdat[0], rdat[1]);
    end
  endtask

  task automatic test_conflict(input logic [15:0] d1, input logic [15:0] d2, input bit core2_first);
    int          first, second;
    logic [15:0] final_val;
    core1_we = 1'b1; core1_addr = 16'd9; core1_wdata = d1; core1_req = 1'b1;
    core2_we = 1'b1; core2_addr = 16'd9; core2_wdata = d2; core2_req = 1'b1;
    run(10);
    first     = core2_first ? ack_c[1] : ack_c[0];
    second    = core2_first ? ack_c[0] : ack_c[1];
    final_val = core2_first ? d1 : d2;
    n_checks++;
    if (first !== 3 || second !== 7) begin
      n_errors++;
      $display("FAIL conflict_order(%h/%h): got winner@%0d loser@%0d want 3/7", d1, d2, first, second);
    end
    n_checks++;
    if (mem[9] !== final_val) begin
      n_errors++;
      $display("FAIL conflict_mem9: got %h want %h", mem[9], final_val);
    end
  endtask

  task automatic test_reset_mid_op;
    bit bad;
    preload(10'd12, 16'h0000);
    core1_we = 1'b1; core1_addr = 16'd12; core1_wdata = 16'h5555; core1_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ram_addr_1 !== 16'd12) begin n_errors++; $display("FAIL midrst_setup_addr: got %0d want 12", ram_addr_1); end
    rst = 1'b1; core1_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_addr_1, ram_din_1, ram_wr_1, ram_rd_1, core1_rdata, core1_ack, core1_err} !== 52'h0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got addr %h din %h wr %b rd %b ack %b want all 0",
               ram_addr_1, ram_din_1, ram_wr_1, ram_rd_1, core1_ack);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ram_wr_1 || core1_ack) bad = 1'b1;
    end
    n_checks++;
    if (bad || mem[12] !== 16'h0000) begin
      n_errors++;
      $display("FAIL midrst_no_commit: got late wr/ack %b mem12 %h want 0 0000", bad, mem[12]);
    end
  endtask

  initial begin
    rst = 1'b1;
    core1_req = 1'b0; core1_we = 1'b0; core1_addr = '0; core1_wdata = '0;
    core2_req = 1'b0; core2_we = 1'b0; core2_addr = '0; core2_wdata = '0;
    test_reset();
    test_store_load();
    test_parallel_loads();
    test_out_of_range();
    test_same_addr_loads();
    test_conflict(16'h1111, 16'h2222, 1'b0);
`ifdef DMEM_RR_ARB_EN
    test_conflict(16'h3333, 16'h4444, 1'b1);
`else
    test_conflict(16'h3333, 16'h4444, 1'b0);
`endif
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Dual-port access controller directly upstream of the dual-port data RAM. It accepts load/store requests from core 1 and core 2 over a req/ack handshake and drives the RAM's per-port WR/RD strobes, 16-bit address and write data. It sequences each access so the address is stable before the read strobe rises, and captures read data. It serialises cross-core accesses that collide on the same address.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- MEM_DEPTH, 1024, implemented RAM words; addresses >= MEM_DEPTH are out of range
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- core{1,2}_req  in  1  access request, level; held until ack
- core{1,2}_we  in  1  1 = store, 0 = load
- core{1,2}_addr  in  ADDR_W  word address
- core{1,2}_wdata  in  DATA_W  store data
- core{1,2}_rdata  out  DATA_W  load data, valid while ack=1
- core{1,2}_ack  out  1  one-cycle completion pulse
- core{1,2}_err  out  1  out-of-range flag, valid while ack=1
- ram_addr_{1,2}  out  ADDR_W  to RAM ADDBUS_1/2
- ram_din_{1,2}  out  DATA_W  to RAM DATAIN_1/2
- ram_wr_{1,2}, ram_rd_{1,2}  out  1  to RAM WR_1/2, RD_1/2
- ram_dout_{1,2}  in  DATA_W  from RAM DATAOUT_1/2

## Operation
- Per-port FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: on grant, latch we/addr/wdata and go to SETUP. Out-of-range address: skip to RESP, err=1, rdata=0, no strobe.
- SETUP: drive ram_addr/ram_din; ram_rd=ram_wr=0.
- ACCESS: ram_wr=we or ram_rd=!we for exactly one cycle; address/data unchanged.
- RESP: ack=1. Load: rdata = ram_dout sampled at the ACCESS->RESP edge. Store: rdata=0. ram_rd back to 0 so the next load produces a fresh rising edge.
- All outputs are registered; ram_rd/ram_wr never change in the same cycle as ram_addr.
- Conflict, same address with at least one store: a new request is not granted while the other port is outside IDLE on that address. On simultaneous same-cycle conflicting requests, core 1 wins. The loser stays in IDLE with req held.
- Loads-only to the same address and any different addresses proceed in parallel.

## Timing
- Request seen at edge E0 -> SETUP E0-E1, ACCESS E1-E2, RESP E2-E3. ack is high for exactly one cycle, 3 cycles after acceptance.
- RESP always returns to IDLE. Back-to-back throughput is one access per 4 cycles per port.
- Reset values: all ram_* outputs 0, all core rdata/ack/err 0, both FSMs in IDLE, round-robin pointer = core 1.
- Reset mid-operation: FSM returns to IDLE and no ack is issued. A store whose ACCESS cycle is in progress at the reset edge still commits, because the RAM samples WR at that edge.
- If req drops before ack, the access still completes and the ack is still issued; the core ignores it.

## Configuration
- DMEM_RR_ARB_EN defined: simultaneous conflicting requests use round-robin. The pointer flips to the other core after each conflict grant.
- DMEM_RR_ARB_EN not defined: fixed priority, core 1 always wins.

## Structure
- Package dmem_pkg: FSM state enum (IDLE, SETUP, ACCESS, RESP), DATA_W/ADDR_W defaults, MEM_DEPTH.
- Sub-module dmem_port_fsm: one instance per port, holding FSM, latches and range check. The top holds conflict detection and the arbiter.

## Test plan
- Core 1 stores 0x00AB at addr 5, then loads addr 5 -> store ack after 3 cycles; load ack with rdata=0x00AB; ram_rd rises one cycle after ram_addr=5.
- Core 1 loads addr 3 and core 2 loads addr 7 in the same cycle -> both acks in the same cycle, rdata = RAM contents; no stall.
- Both cores store to addr 9 in the same cycle (0x1111, 0x2222), fixed priority -> core 1 ack first, core 2 ack 4 cycles later; final mem[9]=0x2222.
- Same as above with DMEM_RR_ARB_EN and a repeated conflict -> second conflict grants core 2 first.
- Core 2 loads addr 1024 -> ack after 1 cycle in RESP path, err=1, rdata=0, ram_rd_2 never asserted.
- rst asserted during SETUP of a store -> no ram_wr pulse, no ack, all outputs 0 the next cycle.
